majority_vote_sequencer: RTL

//  Sequences one shared 5-input bitwise majority datapath over WIDTH-bit words

---
 rtl/maj_vote_pkg.sv | 6 +
 rtl/maj5.sv | 13 +
 rtl/majority_vote_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/maj_vote_pkg.sv
// maj_vote_pkg: shared FSM state type and voting constants for the majority vote sequencer
package maj_vote_pkg;
  typedef enum logic [1:0] {IDLE, VOTE, OUT} state_t;
  localparam int NUM_REPLICAS = 5;
  localparam int MAJ_THRESHOLD = 3;
endpackage

// File: rtl/maj5.sv
// maj5: combinational 5-input 1-bit majority (bits -> maj)
module maj5
  import maj_vote_pkg::*;
(
  input  logic [NUM_REPLICAS-1:0] bits,
  output logic                    maj
);
  logic [2:0] sum;
  always_comb begin
    sum = 3'(bits[0]) + 3'(bits[1]) + 3'(bits[2]) + 3'(bits[3]) + 3'(bits[4]);
    maj = sum >= 3'(MAJ_THRESHOLD);
  end
endmodule

// File: rtl/majority_vote_sequencer.sv
// majority_vote_sequencer: slice-serial 5-replica majority voter with valid/ready handshakes and saturating per-replica error counters
module majority_vote_sequencer
  import maj_vote_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_REPLICAS*WIDTH-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [NUM_REPLICAS-1:0]         out_mask,
  output logic                            out_fault,
  input  logic                            clr_cnt,
  output logic [NUM_REPLICAS*CNT_W-1:0]   err_cnt
);
  localparam int NS = WIDTH / SLICE;
  localparam int IDX_W = NS > 1 ? $clog2(NS) : 1;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] word [NUM_REPLICAS];
  logic [WIDTH-1:0] vote_acc, vote_next;
  logic [NUM_REPLICAS-1:0] mask_acc, slice_diff;
  logic [CNT_W-1:0] cnt [NUM_REPLICAS];
  logic [SLICE-1:0] rep_slice [NUM_REPLICAS];
  logic [SLICE-1:0] voted;
  logic last;
  for (genvar r = 0; r < NUM_REPLICAS; r++) begin : g_rep
    assign rep_slice[r] = word[r][idx*SLICE +: SLICE];
    assign slice_diff[r] = rep_slice[r] != voted;
    assign err_cnt[r*CNT_W +: CNT_W] = cnt[r];
  end
  for (genvar b = 0; b < SLICE; b++) begin : g_maj
    maj5 u_maj5 (
      .bits({rep_slice[4][b], rep_slice[3][b], rep_slice[2][b], rep_slice[1][b], rep_slice[0][b]}),
      .maj (voted[b])
    );
  end
  always_comb begin
    vote_next = vote_acc;
    vote_next[idx*SLICE +: SLICE] = voted;
    last = idx == IDX_W'(NS - 1);
    in_ready = state == IDLE && !rst;
    out_fault = |out_mask;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_mask <= '0;
      vote_acc <= '0;
      mask_acc <= '0;
      for (int r = 0; r < NUM_REPLICAS; r++) begin
        word[r] <= '0;
        cnt[r] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int r = 0; r < NUM_REPLICAS; r++) word[r] <= in_data[r*WIDTH +: WIDTH];
          mask_acc <= '0;
          idx <= '0;
          state <= VOTE;
        end
        VOTE: begin
          vote_acc <= vote_next;
          mask_acc <= mask_acc | slice_diff;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            out_data <= vote_next;
            out_mask <= mask_acc | slice_diff;
            out_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      for (int r = 0; r < NUM_REPLICAS; r++)
        cnt[r] <= clr_cnt ? '0 :
                  (state == OUT && out_ready && out_mask[r] && cnt[r] != '1) ? cnt[r] + 1'b1 : cnt[r];
    end
  end
endmodule
